apb_word_fifo: RTL and testbench

Buffers the 32-bit words produced by the byte-to-word shift stage and makes them available to software over an APB slave port. Each `wr_valid` pulse pushes one word into a parameterised circular FIFO. An APB read of the DATA register pops one word. Status, sticky error flags, flush and an interrupt output let the bus master drain the stream without loss.

---
 rtl/apb_word_fifo.sv | 148 ++++++++++++++
 tb/tb_apb_word_fifo.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_word_fifo.sv
`default_nettype none
// ============================================================================
// Module      : apb_word_fifo
// Description : Circular FIFO of 32-bit words filled by the upstream packer
//               and drained by software through an APB slave. Provides
//               status, sticky overflow/underflow flags, flush and an
//               interrupt while the FIFO is non-empty.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_word_fifo #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic        clk,
    input  logic        res,
    input  logic [31:0] wr_data,
    input  logic        wr_valid,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [7:0]  paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic        irq
);

    localparam logic [5:0]     c_addr_data   = 6'd0;
    localparam logic [5:0]     c_addr_status = 6'd1;
    localparam logic [5:0]     c_addr_ctrl   = 6'd2;
    localparam logic [PTR_W:0] c_full_count  = (PTR_W + 1)'(DEPTH);

    logic [31:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wp;
    logic [PTR_W-1:0] r_rp;
    logic [PTR_W:0]   r_count;
    logic             r_ovf;
    logic             r_udf;
    logic             r_irq_en;

    logic        w_access;
    logic        w_rd;
    logic        w_wr;
    logic [5:0]  w_word;
    logic        w_hit_data;
    logic        w_hit_status;
    logic        w_hit_ctrl;
    logic        w_empty;
    logic        w_full;
    logic        w_flush;
    logic        w_pop;
    logic        w_push;
    logic        w_ovf_set;
    logic        w_udf_set;
    logic        w_sts_wr;
    logic [31:0] w_status;
    logic        w_unused;

    // Gating with reset makes an access that overlaps reset look idle.
    assign w_access     = psel & penable & res;
    assign w_rd         = w_access & ~pwrite;
    assign w_wr         = w_access & pwrite;
    assign w_word       = paddr[7:2];
    assign w_hit_data   = (w_word == c_addr_data);
    assign w_hit_status = (w_word == c_addr_status);
    assign w_hit_ctrl   = (w_word == c_addr_ctrl);

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_full_count);

    // Flush dominates: it suppresses any pop or push on the same edge.
    assign w_flush   = w_wr & w_hit_ctrl & pwdata[1];
    assign w_pop     = w_rd & w_hit_data & ~w_empty & ~w_flush;
    assign w_push    = wr_valid & (~w_full | w_pop) & ~w_flush;
    assign w_ovf_set = wr_valid & w_full & ~w_pop & ~w_flush;
    assign w_udf_set = w_rd & w_hit_data & w_empty;
    assign w_sts_wr  = w_wr & w_hit_status;

    assign w_status = {16'h0000, 8'(r_count), 4'h0, r_udf, r_ovf, w_full, w_empty};

    assign w_unused = &{1'b0, paddr[1:0], pwdata[31:4]};

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + PTR_W'(1);
            if (w_pop)  r_rp <= r_rp + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky flags: a hardware set wins over a same-edge W1C clear.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
            r_irq_en <= 1'b0;
        end else begin
            r_ovf <= w_ovf_set | (r_ovf & ~(w_sts_wr & pwdata[2]));
            r_udf <= w_udf_set | (r_udf & ~(w_sts_wr & pwdata[3]));
            if (w_wr & w_hit_ctrl) r_irq_en <= pwdata[0];
        end
    end

    // Word storage; contents survive flush and reset by design.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= wr_data;
    end

    // APB read mux and error response, valid only in the access phase.
    always_comb begin
        prdata  = '0;
        pslverr = 1'b0;
        if (w_access) begin
            case (w_word)
                c_addr_data: begin
                    pslverr = pwrite | w_empty;
                    if (!pwrite && !w_empty) prdata = r_mem[r_rp];
                end
                c_addr_status: begin
                    if (!pwrite) prdata = w_status;
                end
                c_addr_ctrl: begin
                    if (!pwrite) prdata = {31'h0, r_irq_en};
                end
                default: pslverr = 1'b1;
            endcase
        end
    end

    assign pready = 1'b1;
    assign irq    = r_irq_en & ~w_empty;

endmodule
`default_nettype wire

// File: tb/tb_apb_word_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_word_fifo
// Description : Directed and randomized bench for apb_word_fifo, checked
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_word_fifo;

    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    logic        clk = 1'b0;
    logic        res;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] q[$];
    logic        m_ovf;
    logic        m_udf;
    logic        m_irq_en;

    logic [31:0] last_rd;
    logic        last_err;

    apb_word_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .res(res), .wr_data(wr_data), .wr_valid(wr_valid),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [7:0] a);
        case (a[7:2])
            6'd0:    return (q.size() > 0) ? q[0] : 32'h0;
            6'd1:    return {16'h0, 8'(q.size()), 4'h0, m_udf, m_ovf,
                             q.size() == DEPTH, q.size() == 0};
            6'd2:    return {31'h0, m_irq_en};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic exp_err(input logic wr, input logic [7:0] a);
        case (a[7:2])
            6'd0:       return wr || (q.size() == 0);
            6'd1, 6'd2: return 1'b0;
            default:    return 1'b1;
        endcase
    endfunction

    // Effect of one clock edge on the model.
    task automatic model_edge(input logic push, input logic [31:0] wd, input logic acc,
                              input logic wr, input logic [7:0] a, input logic [31:0] wdv);
        logic ovf_set;
        logic udf_set;
        ovf_set = 1'b0;
        udf_set = 1'b0;
        if (acc && wr && a[7:2] == 6'd2 && wdv[1]) begin
            q.delete();
        end else begin
            if (acc && !wr && a[7:2] == 6'd0) begin
                if (q.size() > 0) void'(q.pop_front());
                else udf_set = 1'b1;
            end
            if (push) begin
                if (q.size() < DEPTH) q.push_back(wd);
                else ovf_set = 1'b1;
            end
        end
        if (acc && wr && a[7:2] == 6'd1) begin
            if (wdv[2]) m_ovf = 1'b0;
            if (wdv[3]) m_udf = 1'b0;
        end
        m_ovf = m_ovf | ovf_set;
        m_udf = m_udf | udf_set;
        if (acc && wr && a[7:2] == 6'd2) m_irq_en = wdv[0];
    endtask

    // One clock cycle: drive, check mid-cycle, advance model, cross edge.
    task automatic step(input logic push, input logic [31:0] wd, input logic s, input logic en,
                        input logic wr, input logic [7:0] a, input logic [31:0] wdv);
        wr_valid = push; wr_data = wd; psel = s; penable = en;
        pwrite = wr; paddr = a; pwdata = wdv;
        #3;
        chk("pready", {31'h0, pready}, 32'h1);
        chk("irq", {31'h0, irq}, {31'h0, m_irq_en && q.size() != 0});
        if (s && en) begin
            if (!wr) begin
                chk("prdata", prdata, exp_rd(a));
                last_rd = prdata;
            end
            chk("pslverr", {31'h0, pslverr}, {31'h0, exp_err(wr, a)});
            last_err = pslverr;
        end else begin
            chk("prdata_idle", prdata, 32'h0);
            chk("pslverr_idle", {31'h0, pslverr}, 32'h0);
        end
        model_edge(push, wd, s && en, wr, a, wdv);
        @(posedge clk);
        #1;
    endtask

    task automatic apb(input logic wr, input logic [7:0] a, input logic [31:0] d,
                       input logic p0, input logic [31:0] w0, input logic p1, input logic [31:0] w1);
        step(p0, w0, 1'b1, 1'b0, wr, a, d);
        step(p1, w1, 1'b1, 1'b1, wr, a, d);
    endtask

    task automatic rd(input logic [7:0] a);
        apb(1'b0, a, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic wrr(input logic [7:0] a, input logic [31:0] d);
        apb(1'b1, a, d, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic push(input logic [31:0] w);
        step(1'b1, w, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
    endtask

    initial begin
        logic [7:0] addrs [6];
        addrs = '{8'h00, 8'h00, 8'h04, 8'h08, 8'h0C, 8'h10};
        res = 1'b0; wr_data = '0; wr_valid = 1'b0; psel = 1'b0; penable = 1'b0;
        pwrite = 1'b0; paddr = '0; pwdata = '0;
        q.delete(); m_ovf = 1'b0; m_udf = 1'b0; m_irq_en = 1'b0;
        last_rd = '0; last_err = 1'b0;

        // Reset values
        #2;
        chk("rst_prdata", prdata, 32'h0);
        chk("rst_pslverr", {31'h0, pslverr}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_pready", {31'h0, pready}, 32'h1);
        @(posedge clk); #1;
        res = 1'b1;

        // Two words, status, ordered drain
        push(32'h11223344);
        push(32'h55667788);
        rd(8'h04); chk("tp_status2", last_rd, 32'h0000_0200);
        rd(8'h00); chk("tp_word0", last_rd, 32'h11223344);
        rd(8'h00); chk("tp_word1", last_rd, 32'h55667788);
        rd(8'h04); chk("tp_status_empty", last_rd, 32'h0000_0001);

        // Overflow: nine pushes into eight entries
        for (int i = 0; i < 9; i++) push(32'hA000_0000 + i);
        rd(8'h04); chk("tp_status_ovf", last_rd, 32'h0000_0806);
        for (int i = 0; i < 8; i++) begin
            rd(8'h00); chk("tp_ovf_drain", last_rd, 32'hA000_0000 + i);
        end
        rd(8'h04); chk("tp_ninth_absent", last_rd, 32'h0000_0005);
        wrr(8'h04, 32'h4);
        rd(8'h04); chk("tp_ovf_w1c", last_rd, 32'h0000_0001);

        // Underflow
        rd(8'h00);
        chk("tp_udf_data", last_rd, 32'h0);
        chk("tp_udf_err", {31'h0, last_err}, 32'h1);
        rd(8'h04); chk("tp_udf_flag", last_rd, 32'h0000_0009);
        wrr(8'h04, 32'h8);
        rd(8'h04); chk("tp_udf_w1c", last_rd, 32'h0000_0001);

        // Full FIFO with simultaneous pop and push
        for (int i = 0; i < 8; i++) push(32'hB000_0000 + i);
        apb(1'b0, 8'h00, 32'h0, 1'b0, 32'h0, 1'b1, 32'hBEEF_0008);
        chk("tp_full_pop", last_rd, 32'hB000_0000);
        rd(8'h04); chk("tp_full_status", last_rd, 32'h0000_0802);
        for (int i = 1; i < 8; i++) begin
            rd(8'h00); chk("tp_full_drain", last_rd, 32'hB000_0000 + i);
        end
        rd(8'h00); chk("tp_new_last", last_rd, 32'hBEEF_0008);

        // Pointer wrap across several laps
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 7; i++) push($urandom);
            for (int i = 0; i < 7; i++) rd(8'h00);
        end

        // Randomized mix checked by the model
        repeat (300) begin
            int op;
            logic p;
            logic [31:0] d;
            logic [7:0] a;
            op = $urandom_range(0, 3);
            p  = 1'($urandom_range(0, 1));
            a  = addrs[$urandom_range(0, 5)] | 8'($urandom_range(0, 3));
            d  = $urandom;
            if ($urandom_range(0, 9) != 0) d[1] = 1'b0;
            case (op)
                0: step(p, $urandom, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
                1: apb(1'b0, a, 32'h0, p, $urandom, 1'($urandom_range(0, 1)), $urandom);
                2: apb(1'b1, a, d, p, $urandom, 1'($urandom_range(0, 1)), $urandom);
                default: apb(1'b0, 8'h00, 32'h0, p, $urandom, 1'($urandom_range(0, 1)), $urandom);
            endcase
        end

        // Interrupt and flush
        wrr(8'h08, 32'h2);
        wrr(8'h04, 32'hC);
        wrr(8'h08, 32'h1);
        push(32'hD000_0001);
        chk("tp_irq_rise", {31'h0, irq}, 32'h1);
        apb(1'b1, 8'h08, 32'h3, 1'b0, 32'h0, 1'b1, 32'hDEAD_0000);
        chk("tp_irq_fall", {31'h0, irq}, 32'h0);
        rd(8'h04); chk("tp_flush_status", last_rd, 32'h0000_0001);

        // Reset in the middle of a transfer with five words stored
        for (int i = 0; i < 5; i++) push(32'hE000_0000 + i);
        rd(8'h04); chk("tp_five", last_rd, 32'h0000_0500);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 8'h00; wr_valid = 1'b1;
        #2;
        res = 1'b0;
        #1;
        chk("tp_midrst_prdata", prdata, 32'h0);
        chk("tp_midrst_pslverr", {31'h0, pslverr}, 32'h0);
        chk("tp_midrst_irq", {31'h0, irq}, 32'h0);
        chk("tp_midrst_pready", {31'h0, pready}, 32'h1);
        q.delete(); m_ovf = 1'b0; m_udf = 1'b0; m_irq_en = 1'b0;
        psel = 1'b0; penable = 1'b0; wr_valid = 1'b0;
        @(posedge clk); #1;
        res = 1'b1;
        rd(8'h04); chk("tp_after_rst", last_rd, 32'h0000_0001);
        rd(8'h08); chk("tp_after_rst_ctrl", last_rd, 32'h0);
        rd(8'h10); chk("tp_bad_addr", {31'h0, last_err}, 32'h1);
        wrr(8'h10, 32'hFFFF_FFFF);
        rd(8'h04); chk("tp_bad_write_noeffect", last_rd, 32'h0000_0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
